uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter between two requesters, e.g. the CPU MMIO store path and the debug/echo path. Each requester hands over a 32-bit word plus a byte count. The block accepts one request at a time, then serializes the captured bytes LSB-first through the UART Tx `tx_send`/`tx_sent` handshake. It signals per-requester completion and sits between the bus-side peripheral logic and UART_Tx.

Parameters:
WORD_BYTES, 4, maximum bytes per request; the data width is 8*WORD_BYTES.
LEN_W, 2, width of the length field; it must satisfy 2^LEN_W >= WORD_BYTES.
TIMEOUT_CYCLES, 1048576, cycles to wait in WAIT before abort; used only with the optional feature.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a word pending; held until req0_ready
req0_data  in  8*WORD_BYTES  requester 0 payload; byte 0 = bits [7:0]
req0_len  in  LEN_W  requester 0 byte count minus 1
req0_ready  out  1  one-cycle pulse: request 0 captured
req0_done  out  1  one-cycle pulse: last byte of request 0 sent, or aborted
req1_valid, req1_data, req1_len, req1_ready, req1_done  same as above, for requester 1
uart_send  out  1  drives UART_Tx `tx_send`; one-cycle pulse per byte
uart_data  out  8  drives UART_Tx `tx_data`
uart_sent  in  1  UART_Tx `tx_sent`; a one-cycle pulse when the frame completes
busy  out  1  high in every state except IDLE
grant  out  1  index of the requester currently owned or last served
err_timeout  out  1  one-cycle pulse coincident with done on abort

Behaviour:
- All outputs are registered.
- Reset values: every pulse output = 0, uart_data = 0, busy = 0, grant = 1 (so requester 0 wins the first tie), state = IDLE, shift register = 0, byte counter = 0.
- States: IDLE, SEND, WAIT, NEXT, DONE.
- IDLE:
  - If any valid is high, pick a winner. A single valid requester wins. If both are valid, the winner is ~grant (round-robin).
  - Capture the winner's data into the shift register and its len into the counter. Set grant to the winner, pulse its ready next cycle, go to SEND.
- SEND:
  - uart_send = 1 for exactly this one cycle, with uart_data = shift[7:0]. Go to WAIT.
- WAIT:
  - uart_data is held stable; uart_send = 0.
  - On uart_sent = 1: if counter == 0, go to DONE; otherwise go to NEXT.
- NEXT:
  - Shift register right by 8 with zero fill; decrement counter; go to SEND.
- DONE:
  - Pulse done of the granted requester for one cycle; go to IDLE.
- Latency:
  - valid is sampled at edge t; ready is high in cycle t+1; the first uart_send is high in cycle t+1 (SEND entered at t+1).
  - Gap between uart_sent and the next uart_send is 2 cycles (NEXT, then SEND).
- Request length: len = 0 sends 1 byte; len = WORD_BYTES-1 sends the full word. If len >= WORD_BYTES, it is clamped to WORD_BYTES-1.
- uart_sent is ignored in IDLE, SEND, NEXT and DONE. A stray pulse in these states has no effect.
- A valid that arrives while busy is held off and is not accepted before the return to IDLE. Minimum spacing from one done pulse to the next ready pulse is 2 cycles.
- Both valid and grant = 0: requester 1 wins, then requester 0 on the following round. A continuously-valid requester is never starved.
- Reset mid-operation: return to IDLE immediately and drop uart_send. A UART frame already in flight is not aborted here, because UART_Tx has its own reset. No done pulse is issued for the interrupted request.
- Requesters must not change data or len between asserting valid and seeing ready.

Optional Feature:
UART_TX_ARB_TIMEOUT_EN
- Defined: a WAIT-state counter clears on entry to WAIT. If it reaches TIMEOUT_CYCLES-1 without uart_sent, the FSM goes to DONE and issues done plus err_timeout in the same cycle; remaining bytes are discarded. uart_sent arriving on the terminal count cycle has priority, giving a normal completion.
- Undefined: no counter is built, WAIT waits indefinitely, and err_timeout is tied to 0.

Test Plan:
- Reset: assert rst for 2 cycles, then idle with no requests -> all outputs 0, grant = 1, busy = 0.
- Single word: req0 valid, data = 0x44332211, len = 3; model sent pulses 20 cycles after each send -> uart_data sequence 0x11, 0x22, 0x33, 0x44, four send pulses, req0_ready once, req0_done once after the 4th sent, busy low 1 cycle later.
- Tie arbitration: both valid from reset, req0 data 0xAA (len 0), req1 data 0xBB (len 0), both held -> 0xAA sent first and then 0xBB; repeat with both valid again -> order continues 0xAA, 0xBB (alternating).
- Short length and clamp: req1 len = 1, data 0x0000CDEF -> bytes 0xEF, 0xCD, then done. A len value clamped above WORD_BYTES-1 sends 4 bytes.
- Stray sent and reset mid-word: pulse uart_sent in IDLE -> no state change. Start a len = 3 request and assert rst after the 2nd byte -> IDLE next cycle, no done, uart_send stays 0.
- Timeout (macro defined, TIMEOUT_CYCLES = 16): never return uart_sent -> done and err_timeout pulse 16 cycles after the send, then IDLE. With the macro undefined -> busy remains high.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between two word-wide requesters.
// Optional WAIT-state abort timer is built when UART_TX_ARB_TIMEOUT_EN is defined.

module uart_tx_arbiter #(
    parameter int WORD_BYTES     = 4,
    parameter int LEN_W          = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req0_valid,
    input  logic [8*WORD_BYTES-1:0] req0_data,
    input  logic [LEN_W-1:0]        req0_len,
    output logic                    req0_ready,
    output logic                    req0_done,

    input  logic                    req1_valid,
    input  logic [8*WORD_BYTES-1:0] req1_data,
    input  logic [LEN_W-1:0]        req1_len,
    output logic                    req1_ready,
    output logic                    req1_done,

    output logic                    uart_send,
    output logic [7:0]              uart_data,
    input  logic                    uart_sent,

    output logic                    busy,
    output logic                    grant,
    output logic                    err_timeout
);

    localparam int                DATA_W  = 8 * WORD_BYTES;
    localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        NEXT,
        DONE
    } state_t;

    state_t              state, state_next;
    logic [DATA_W-1:0]   shift, shift_next;
    logic [LEN_W-1:0]    cnt, cnt_next;
    logic                grant_next;
    logic                winner;
    logic                accept;
    logic                abort;
    logic                timeout_hit;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;

    // Held at zero outside WAIT, so every WAIT visit starts counting from 0.
    always_ff @(posedge clk) begin
        if (rst || state != WAIT) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (state == WAIT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_next = state;
        shift_next = shift;
        cnt_next   = cnt;
        grant_next = grant;
        winner     = 1'b0;
        accept     = 1'b0;
        abort      = 1'b0;

        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    winner     = (req0_valid && req1_valid) ? ~grant : req1_valid;
                    accept     = 1'b1;
                    grant_next = winner;
                    shift_next = winner ? req1_data : req0_data;
                    cnt_next   = clamp_len(winner ? req1_len : req0_len);
                    state_next = SEND;
                end
            end
            SEND: begin
                state_next = WAIT;
            end
            WAIT: begin
                // A frame completing on the terminal count wins over the abort.
                if (uart_sent) begin
                    state_next = (cnt == '0) ? DONE : NEXT;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            NEXT: begin
                shift_next = shift >> 8;
                cnt_next   = cnt - LEN_W'(1);
                state_next = SEND;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is ordinary flops, not a memory, so it is reset with everything else.
            state       <= IDLE;
            shift       <= '0;
            cnt         <= '0;
            grant       <= 1'b1;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            req0_done   <= 1'b0;
            req1_done   <= 1'b0;
            uart_send   <= 1'b0;
            uart_data   <= 8'h00;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking only; outputs are registered from next-state so they line up with it.
            state       <= state_next;
            shift       <= shift_next;
            cnt         <= cnt_next;
            grant       <= grant_next;
            req0_ready  <= accept && !winner;
            req1_ready  <= accept && winner;
            uart_send   <= (state_next == SEND);
            if (state_next == SEND) begin
                uart_data <= shift_next[7:0];
            end
            req0_done   <= (state_next == DONE) && !grant;
            req1_done   <= (state_next == DONE) && grant;
            busy        <= (state_next != IDLE);
            err_timeout <= abort;
        end
    end

endmodule
